// File: rtl/ser_pkg.sv
// Shared types for the bit serializer.
// Holds the FSM state encoding and the default word width.
package ser_pkg;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SHIFT,
    SER_PARITY
  } ser_state_t;

  localparam int SER_DEF_W = 8;

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable down-counter for the serializer bit index.
// Saturates at zero; the zero flag marks the final data bit.
module ser_bit_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  assign zero = (cnt == '0);

  // Load wins over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end with zero-bubble reload.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int W         = SER_DEF_W,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         bit_en,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_last
);

  localparam int CNT_W = $clog2(W);

  ser_state_t       state;
  logic [W-1:0]     shreg;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_dec;
  logic             frame_done;
  logic             accept;

`ifdef SER_PARITY_EN
  logic par_bit;
  assign frame_done = bit_en && (state == SER_PARITY);
`else
  assign frame_done = bit_en && (state == SER_SHIFT) && cnt_zero;
`endif

  // Ready in IDLE or as the last frame bit leaves, so reload is gap-free.
  assign s_ready = !rst && ((state == SER_IDLE) || frame_done);
  assign accept  = s_valid && s_ready;
  assign cnt_dec = (state == SER_SHIFT) && bit_en;

  ser_bit_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (CNT_W'(W - 1)),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // FSM, shift register and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SER_IDLE;
      shreg     <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
`ifdef SER_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else if (accept) begin
      state     <= SER_SHIFT;
      shreg     <= s_data;
      ser_out   <= (MSB_FIRST != 0) ? s_data[W-1] : s_data[0];
      ser_valid <= 1'b1;
      ser_last  <= 1'b0;
`ifdef SER_PARITY_EN
      par_bit   <= ^s_data;
`endif
    end else begin
      case (state)
        SER_IDLE: begin
        end
        SER_SHIFT: begin
          if (bit_en) begin
            if (cnt_zero) begin
`ifdef SER_PARITY_EN
              state     <= SER_PARITY;
              ser_out   <= par_bit;
              ser_last  <= 1'b1;
`else
              state     <= SER_IDLE;
              ser_out   <= 1'b0;
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
`endif
            end else begin
              if (MSB_FIRST != 0) begin
                shreg   <= shreg << 1;
                ser_out <= shreg[W-2];
              end else begin
                shreg   <= shreg >> 1;
                ser_out <= shreg[1];
              end
`ifndef SER_PARITY_EN
              ser_last <= (cnt == CNT_W'(1));
`endif
            end
          end
        end
`ifdef SER_PARITY_EN
        SER_PARITY: begin
          if (bit_en) begin
            state     <= SER_IDLE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
          end
        end
`endif
        default: begin
          state <= SER_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (MSB-first and LSB-first).
// Directed frames plus a randomized run against a bit-queue model.
module tb_bit_serializer;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         bit_en = 1'b0;

  logic m_ready, m_out, m_valid, m_last;
  logic l_ready, l_out, l_valid, l_last;

  int checks = 0;
  int failures = 0;

  bit mq[$];
  bit lq[$];

  always #5 clk = ~clk;

  bit_serializer #(.W(W), .MSB_FIRST(1)) dut_m (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (m_ready),
    .bit_en    (bit_en),
    .ser_out   (m_out),
    .ser_valid (m_valid),
    .ser_last  (m_last)
  );

  bit_serializer #(.W(W), .MSB_FIRST(0)) dut_l (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (l_ready),
    .bit_en    (bit_en),
    .ser_out   (l_out),
    .ser_valid (l_valid),
    .ser_last  (l_last)
  );

  // Bit k of the frame for word w; index W is the even-parity bit.
  function automatic bit exp_bit(input logic [W-1:0] w, input int k,
                                 input bit msb);
    if (k >= W) return ^w;
    return msb ? w[W-1-k] : w[k];
  endfunction

  // Reference model: queue of frame bits still to be emitted.
  always @(posedge clk) begin : model
    bit acc;
    if (rst) begin
      mq.delete();
      lq.delete();
    end else begin
      acc = s_valid &&
            (mq.size() == 0 || (mq.size() == 1 && bit_en));
      if (mq.size() != 0 && bit_en) begin
        void'(mq.pop_front());
        void'(lq.pop_front());
      end
      if (acc) begin
        for (int k = 0; k < F; k++) begin
          mq.push_back(exp_bit(s_data, k, 1'b1));
          lq.push_back(exp_bit(s_data, k, 1'b0));
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    bit_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_out !== 1'b0 ||
        m_ready !== 1'b0 || l_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state valid=%b last=%b out=%b ready=%b/%b want 0",
               m_valid, m_last, m_out, m_ready, l_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (m_ready !== 1'b1 || l_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release ready=%b/%b want 1", m_ready, l_ready);
    end
  endtask

  task automatic test_word(input logic [W-1:0] w);
    bit_en = 1'b1;
    s_data = w;
    s_valid = 1'b1;
    #1;
    checks++;
    if (m_ready !== 1'b1) begin
      failures++;
      $display("FAIL word_ready w=%h ready=%b want 1", w, m_ready);
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_data = W'($urandom);
    for (int k = 0; k < F; k++) begin
      checks++;
      if (m_valid !== 1'b1 || l_valid !== 1'b1 ||
          m_out !== exp_bit(w, k, 1'b1) ||
          l_out !== exp_bit(w, k, 1'b0) ||
          m_last !== (k == F - 1) || l_last !== (k == F - 1)) begin
        failures++;
        $display("FAIL word_bit w=%h k=%0d v=%b%b o=%b%b l=%b%b want o=%b%b l=%b",
                 w, k, m_valid, l_valid, m_out, l_out, m_last, l_last,
                 exp_bit(w, k, 1'b1), exp_bit(w, k, 1'b0), k == F - 1);
      end
      @(negedge clk);
    end
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0) begin
      failures++;
      $display("FAIL word_end w=%h valid=%b last=%b want 0", w, m_valid, m_last);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] wa;
    logic [W-1:0] wb;
    logic [W-1:0] cur;
    int k;
    bit want_rdy;
    wa = 8'hA5;
    wb = 8'h5A;
    bit_en = 1'b1;
    s_valid = 1'b1;
    s_data = wa;
    for (int t = 0; t <= 2 * F; t++) begin
      #1;
      want_rdy = (t == 0) || (t == F) || (t == 2 * F);
      checks++;
      if (m_ready !== want_rdy) begin
        failures++;
        $display("FAIL b2b_ready t=%0d ready=%b want %b", t, m_ready, want_rdy);
      end
      if (t >= 1) begin
        cur = (t <= F) ? wa : wb;
        k = (t - 1) % F;
        checks++;
        if (m_valid !== 1'b1 || m_out !== exp_bit(cur, k, 1'b1) ||
            m_last !== (k == F - 1)) begin
          failures++;
          $display("FAIL b2b_bit t=%0d v=%b o=%b l=%b want v=1 o=%b l=%b",
                   t, m_valid, m_out, m_last, exp_bit(cur, k, 1'b1),
                   k == F - 1);
        end
      end
      if (t == 1) s_data = wb;
      if (t == F + 1) s_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] w;
    int k;
    w = 8'hF0;
    k = 0;
    bit_en = 1'b1;
    s_valid = 1'b1;
    s_data = w;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    for (int c = 1; c < 2 * F; c++) begin
      bit_en = (c % 2) == 1;
      checks++;
      if (m_valid !== 1'b1 || m_out !== exp_bit(w, k, 1'b1) ||
          m_last !== (k == F - 1)) begin
        failures++;
        $display("FAIL stall_bit c=%0d k=%0d v=%b o=%b l=%b want o=%b l=%b",
                 c, k, m_valid, m_out, m_last, exp_bit(w, k, 1'b1),
                 k == F - 1);
      end
      if (k < W) begin
        checks++;
        if (int'(dut_m.cnt) != W - 1 - k) begin
          failures++;
          $display("FAIL stall_cnt c=%0d cnt=%0d want %0d",
                   c, dut_m.cnt, W - 1 - k);
        end
      end
      if (bit_en) k++;
      @(negedge clk);
    end
    bit_en = 1'b1;
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_end valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit_en = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hFF;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_out !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre valid=%b out=%b want 1 1", m_valid, m_out);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_state valid=%b last=%b ready=%b want 0",
               m_valid, m_last, m_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (m_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ready ready=%b want 1", m_ready);
    end
  endtask

  task automatic test_random();
    bit ev;
    bit er;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      bit_en = ($urandom_range(0, 3) != 0);
      s_data = W'($urandom);
      #1;
      ev = (mq.size() != 0);
      er = !rst && (mq.size() == 0 || (mq.size() == 1 && bit_en));
      checks++;
      if (m_valid !== ev || l_valid !== ev ||
          m_ready !== er || l_ready !== er) begin
        failures++;
        $display("FAIL rand_hs c=%0d v=%b%b r=%b%b want v=%b r=%b",
                 c, m_valid, l_valid, m_ready, l_ready, ev, er);
      end
      if (ev) begin
        checks++;
        if (m_out !== mq[0] || l_out !== lq[0] ||
            m_last !== (mq.size() == 1) || l_last !== (lq.size() == 1)) begin
          failures++;
          $display("FAIL rand_bit c=%0d o=%b%b l=%b%b want o=%b%b l=%b",
                   c, m_out, l_out, m_last, l_last, mq[0], lq[0],
                   mq.size() == 1);
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;
    s_valid = 1'b0;
    bit_en = 1'b1;
    repeat (F + 2) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || mq.size() != 0) begin
      failures++;
      $display("FAIL rand_drain valid=%b left=%0d want 0", m_valid, mq.size());
    end
  endtask

  initial begin
    test_reset();
    test_word(8'h36);
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_word(8'h01);
    test_word(8'h07);
    test_word(8'h03);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
